// File: rtl/sps_burst_sequencer_pkg.sv
// sps_pkg: shared widths, frame phase constants and state encoding for the SPS burst sequencer
package sps_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int FRAME_LEN = 23;
  localparam int LEN_W = 8;
  localparam logic [4:0] PH_SHIFT_START = 5'd2;
  localparam logic [4:0] PH_DATA_LAST = 5'd17;
  localparam logic [4:0] PH_ADDR_LAST = 5'd21;
  localparam logic [4:0] PH_FRAME_END = 5'(FRAME_LEN - 1);
  localparam logic [2:0] RWS_NOP = 3'b000;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DRAIN} state_t;
  function automatic logic [1:0] fix_bytesel(input logic [1:0] b);
    return b == 2'b00 ? 2'b11 : b;
  endfunction
endpackage

// File: rtl/sps_burst_sequencer_if.sv
// sps_burst_sequencer_if: burst command and write-data handshakes between a command source and the sequencer
interface sps_burst_sequencer_if;
  import sps_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [1:0] cmd_bytesel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic wr_valid;
  logic wr_ready;
  logic [DATA_W-1:0] wr_data;
  modport master (
    output cmd_valid, cmd_write, cmd_bytesel, cmd_addr, cmd_len, wr_valid, wr_data,
    input cmd_ready, wr_ready
  );
  modport slave (
    input cmd_valid, cmd_write, cmd_bytesel, cmd_addr, cmd_len, wr_valid, wr_data,
    output cmd_ready, wr_ready
  );
endinterface

// File: rtl/sps_burst_sequencer_shifter.sv
// sps_frame_shifter: free-running frame phase counter with per-frame address/data load-and-shift serialisers
module sps_frame_shifter
  import sps_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_ld,
    input  logic [DATA_W-1:0] data_ld,
    output logic [4:0]        phase,
    output logic              frame_end,
    output logic              serial_addr,
    output logic              serial_data
);
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic addr_win, data_win;
    assign frame_end = phase == PH_FRAME_END;
    assign addr_win = phase >= PH_SHIFT_START && phase <= PH_ADDR_LAST;
    assign data_win = phase >= PH_SHIFT_START && phase <= PH_DATA_LAST;
    assign serial_addr = addr_win & addr_sr[ADDR_W-1];
    assign serial_data = data_win & data_sr[DATA_W-1];
    // Registers reload on the edge leaving the frame-end phase, so each frame sees stable contents from phase 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            addr_sr <= '0;
            data_sr <= '0;
        end else begin
            phase <= frame_end ? 5'd0 : phase + 5'd1;
            addr_sr <= frame_end ? addr_ld : addr_win ? addr_sr << 1 : addr_sr;
            data_sr <= frame_end ? data_ld : data_win ? data_sr << 1 : data_sr;
        end
    end
endmodule

// File: rtl/sps_burst_sequencer.sv
// sps_burst_sequencer: turns one burst command into a train of 23-cycle MRAM frames with serial address/data
module sps_burst_sequencer
  import sps_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    sps_burst_sequencer_if.slave bus,
    output logic [2:0] read_write_sel,
    output logic       serial_addr,
    output logic       serial_data,
    output logic [4:0] phase,
    output logic       busy,
    output logic       burst_done,
    output logic       underrun
);
    state_t state, state_n;
    logic op, last, hold_full, all_loaded, frame_end;
    logic [1:0] bytesel;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0] remaining, loads_left;
    logic [DATA_W-1:0] hold;
    logic accept, wr_fire, issue_slot, issue, stall, done;
    assign bus.cmd_ready = state == IDLE;
    assign bus.wr_ready = (state == ARMED || state == ACTIVE) && op && !hold_full && !all_loaded;
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        issue_slot = frame_end && (state == ARMED || (state == ACTIVE && !last));
        issue = issue_slot && (!op || hold_full);
        stall = issue_slot && op && !hold_full;
        done = frame_end && ((state == ACTIVE && last && op) || state == DRAIN);
        state_n = state;
        if (state == IDLE && accept) state_n = ARMED;
        else if (frame_end)
            state_n = state == ARMED ? ACTIVE :
                      state == DRAIN ? IDLE :
                      (state == ACTIVE && last) ? (op ? IDLE : DRAIN) : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op <= 1'b0;
            bytesel <= 2'b00;
            cur_addr <= '0;
            remaining <= '0;
            loads_left <= '0;
            last <= 1'b0;
            hold <= '0;
            hold_full <= 1'b0;
            all_loaded <= 1'b0;
            read_write_sel <= RWS_NOP;
            burst_done <= 1'b0;
            underrun <= 1'b0;
        end else begin
            burst_done <= done;
            if (frame_end) read_write_sel <= issue ? {bytesel, op} : RWS_NOP;
            if (accept) begin
                op <= bus.cmd_write;
                bytesel <= fix_bytesel(bus.cmd_bytesel);
                cur_addr <= bus.cmd_addr;
                remaining <= bus.cmd_len;
                loads_left <= bus.cmd_len;
                last <= 1'b0;
                all_loaded <= 1'b0;
                underrun <= 1'b0;
            end
            if (issue) begin
                cur_addr <= cur_addr + 1'b1;
                last <= remaining == '0;
                if (remaining != '0) remaining <= remaining - 1'b1;
                if (op) hold_full <= 1'b0;
            end
            if (stall) underrun <= 1'b1;
            // wr_ready excludes a full hold, so a load never collides with the issue that empties it
            if (wr_fire) begin
                hold <= bus.wr_data;
                hold_full <= 1'b1;
                all_loaded <= loads_left == '0;
                if (loads_left != '0) loads_left <= loads_left - 1'b1;
            end
        end
    end
    sps_frame_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .addr_ld    (issue ? cur_addr : '0),
        .data_ld    (issue && op ? hold : '0),
        .phase      (phase),
        .frame_end  (frame_end),
        .serial_addr(serial_addr),
        .serial_data(serial_data)
    );
endmodule

// File: tb/tb_sps_burst_sequencer.sv
// tb_sps_burst_sequencer: directed bursts with a frame/done scoreboard decoupled from stimulus
module tb_sps_burst_sequencer;
    import sps_pkg::*;
    typedef struct {
        bit          is_done;
        logic [2:0]  rws;
        logic [19:0] addr;
        logic [15:0] data;
        int          gap;
        bit          prev_nop;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] read_write_sel;
    logic serial_addr, serial_data, busy, burst_done, underrun;
    logic [4:0] phase;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    sps_burst_sequencer_if bus();
    sps_burst_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .read_write_sel(read_write_sel),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .phase         (phase),
        .busy          (busy),
        .burst_done    (burst_done),
        .underrun      (underrun)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [2:0] rws, input logic [19:0] a, input logic [15:0] d, input int gap);
        exp_t e;
        e = '{is_done: 1'b0, rws: rws, addr: a, data: d, gap: gap, prev_nop: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input bit prev_nop);
        exp_t e;
        e = '{is_done: 1'b1, rws: 3'b000, addr: 20'h0, data: 16'h0, gap: 2, prev_nop: prev_nop};
        exp_q.push_back(e);
    endtask

    // Frame monitor: accumulates serial bits over a frame and scores each issued frame and each done pulse
    logic [2:0] cur_rws;
    logic [19:0] abits;
    logic [15:0] dbits;
    bit clean, in_frame, last_nop;
    int nop_cnt;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_frame = 0;
            nop_cnt = 0;
            last_nop = 0;
        end else begin
            if (phase == 5'd0) begin
                cur_rws = read_write_sel;
                abits = '0;
                dbits = '0;
                clean = 1;
                in_frame = 1;
            end else if (read_write_sel != cur_rws) clean = 0;
            if (phase >= 5'd2 && phase <= 5'd21) abits = {abits[18:0], serial_addr};
            else if (serial_addr) clean = 0;
            if (phase >= 5'd2 && phase <= 5'd17) dbits = {dbits[14:0], serial_data};
            else if (serial_data) clean = 0;
            if (burst_done) begin
                chk("done_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("event_kind_done", 1, 32'(e.is_done));
                    chk("done_phase", 32'(phase), 0);
                    chk("done_prev_nop", 32'(last_nop), 32'(e.prev_nop));
                end
                nop_cnt = 0;
            end
            if (phase == PH_FRAME_END && in_frame) begin
                if (cur_rws != RWS_NOP) begin
                    chk("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("event_kind_frame", 0, 32'(e.is_done));
                        chk("frame_rws", 32'(cur_rws), 32'(e.rws));
                        chk("frame_addr", 32'(abits), 32'(e.addr));
                        chk("frame_data", 32'(dbits), 32'(e.data));
                        chk("frame_clean", 32'(clean), 1);
                        if (e.gap == 0) chk("frame_gap_none", nop_cnt, 0);
                        if (e.gap == 1) chk("frame_gap_nop", 32'(nop_cnt > 0), 1);
                    end
                    nop_cnt = 0;
                    last_nop = 0;
                end else begin
                    nop_cnt++;
                    last_nop = 1;
                end
            end
        end
    end

    task automatic send_cmd(input bit w, input logic [1:0] bs, input logic [19:0] a, input logic [7:0] len);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_write = w;
            bus.cmd_bytesel = bs;
            bus.cmd_addr = a;
            bus.cmd_len = len;
            if (bus.cmd_ready) break;
            n++;
            if (n > 500) begin
                $display("FAIL cmd_accept_timeout: got busy expected accept");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            bus.wr_valid = 1'b1;
            bus.wr_data = d;
            if (bus.wr_ready) break;
            n++;
            if (n > 500) begin
                $display("FAIL wr_accept_timeout: got wr_ready=0 expected 1");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1 bus.wr_valid = 1'b0;
    endtask

    task automatic wait_burst(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 1000);
        chk(name, 32'(exp_q.size() == 0 && !busy), 1);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_bytesel = 2'b00;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_rws", 32'(read_write_sel), 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        #2 rst = 1'b0;

        // write burst, data offered early
        push_frame(3'b111, 20'h00010, 16'hA5A5, 2);
        push_frame(3'b111, 20'h00011, 16'h1234, 0);
        push_frame(3'b111, 20'h00012, 16'hFFFF, 0);
        push_done(0);
        send_cmd(1, 2'b11, 20'h00010, 8'd2);
        send_word(16'hA5A5);
        send_word(16'h1234);
        send_word(16'hFFFF);
        wait_burst("write_burst_complete");
        chk("write_underrun", 32'(underrun), 0);

        // read burst with a second command held high while busy
        push_frame(3'b010, 20'h00100, 16'h0000, 2);
        push_frame(3'b010, 20'h00101, 16'h0000, 0);
        push_done(1);
        push_frame(3'b110, 20'hFFFFF, 16'h0000, 2);
        push_frame(3'b110, 20'h00000, 16'h0000, 0);
        push_done(1);
        send_cmd(0, 2'b01, 20'h00100, 8'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_bytesel = 2'b00;
        bus.cmd_addr = 20'hFFFFF;
        bus.cmd_len = 8'd1;
        repeat (40) @(negedge clk);
        chk("busy_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("busy_flag", 32'(busy), 1);
        chk("read_wr_ready", 32'(bus.wr_ready), 0);
        send_cmd(0, 2'b00, 20'hFFFFF, 8'd1);
        wait_burst("read_wrap_complete");

        // underrun: second word withheld well past the next frame boundary
        push_frame(3'b101, 20'h00200, 16'h0F0F, 2);
        push_frame(3'b101, 20'h00201, 16'hF0F0, 1);
        push_done(0);
        send_cmd(1, 2'b10, 20'h00200, 8'd1);
        send_word(16'h0F0F);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_ready && n < 200);
        chk("hold_refill_ready", 32'(bus.wr_ready), 1);
        repeat (30) @(negedge clk);
        chk("underrun_set", 32'(underrun), 1);
        send_word(16'hF0F0);
        wait_burst("underrun_complete");
        chk("underrun_sticky", 32'(underrun), 1);

        // reset at phase 9 of the second write frame
        push_frame(3'b111, 20'h00040, 16'h1111, 2);
        send_cmd(1, 2'b11, 20'h00040, 8'd3);
        chk("underrun_cleared", 32'(underrun), 0);
        send_word(16'h1111);
        send_word(16'h2222);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase != PH_FRAME_END && n < 100);
        do begin
            @(negedge clk);
            n++;
        end while (phase != 5'd9 && n < 200);
        chk("frame2_issued", 32'(read_write_sel), 32'h7);
        chk("frame1_seen", exp_q.size(), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 0);
        chk("arst_rws", 32'(read_write_sel), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("arst_wr_ready", 32'(bus.wr_ready), 0);
        chk("arst_serial", 32'({serial_addr, serial_data}), 0);
        chk("arst_done", 32'(burst_done), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_reset_idle", 32'({busy, read_write_sel}), 0);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
